// File: rtl/rvv_backend_uop_queue.sv
// Multi-push / multi-pop circular uop queue between decode and dispatch.
// Optional sticky error output err_uq is enabled by defining RVV_UQ_ERR_EN.
module rvv_backend_uop_queue #(
  parameter type         DTYPE    = logic [31:0],
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NUM_PUSH = 4,
  parameter int unsigned NUM_POP  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PUSH-1:0] push,
  input  DTYPE                datain [NUM_PUSH],
  output logic                fifo_full,
  output logic [NUM_PUSH-1:1] fifo_almost_full,
  input  logic [NUM_POP-1:0]  pop,
  output DTYPE                dataout [NUM_POP],
  output logic                fifo_empty,
  output logic [NUM_POP-1:1]  fifo_almost_empty
`ifdef RVV_UQ_ERR_EN
  ,
  output logic                err_uq
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, widx;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free, push_req, pop_req, npush, npop, rank;
  DTYPE          mem_q [DEPTH];
  DTYPE          mem_d [DEPTH];

  // Both sides see the start-of-cycle count, so a pop never makes room for a same-cycle push.
  always_comb begin
    free     = CW'(DEPTH) - count_q;
    push_req = '0;
    pop_req  = '0;
    for (int i = 0; i < NUM_PUSH; i++) push_req = push_req + CW'(push[i]);
    for (int i = 0; i < NUM_POP; i++)  pop_req  = pop_req + CW'(pop[i]);
    npush = (push_req > free)    ? free    : push_req;
    npop  = (pop_req  > count_q) ? count_q : pop_req;

    // Set push bits are compacted in slot order; any beyond the free space are dropped.
    mem_d = mem_q;
    rank  = '0;
    widx  = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (push[i]) begin
        if (rank < free) begin
          widx        = wptr_q + rank[AW-1:0];
          mem_d[widx] = datain[i];
        end
        rank = rank + 1'b1;
      end
    end

    wptr_d  = wptr_q + npush[AW-1:0];
    rptr_d  = rptr_q + npop[AW-1:0];
    count_d = count_q + npush - npop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    fifo_full         = (count_q == CW'(DEPTH));
    fifo_empty        = (count_q == '0);
    fifo_almost_full  = '0;
    fifo_almost_empty = '0;
    for (int i = 1; i < NUM_PUSH; i++) fifo_almost_full[i]  = (free == CW'(i));
    for (int i = 1; i < NUM_POP; i++)  fifo_almost_empty[i] = (count_q == CW'(i));
    for (int i = 0; i < NUM_POP; i++)  dataout[i] = mem_q[rptr_q + AW'(i)];
  end

`ifdef RVV_UQ_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (push_req > free) | (pop_req > count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_uq = err_q;
`endif

endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// Directed table-driven bench for rvv_backend_uop_queue (DEPTH=16, NUM_PUSH=4, NUM_POP=2).
module tb_rvv_backend_uop_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  push = '0;
  logic [31:0] datain [4];
  logic        fifo_full;
  logic [3:1]  fifo_almost_full;
  logic [1:0]  pop = '0;
  logic [31:0] dataout [2];
  logic        fifo_empty;
  logic [1:1]  fifo_almost_empty;
`ifdef RVV_UQ_ERR_EN
  logic        err_uq;
`endif

  int checks = 0;
  int errors = 0;

  rvv_backend_uop_queue #(
    .DTYPE    (logic [31:0]),
    .DEPTH    (16),
    .NUM_PUSH (4),
    .NUM_POP  (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .push              (push),
    .datain            (datain),
    .fifo_full         (fifo_full),
    .fifo_almost_full  (fifo_almost_full),
    .pop               (pop),
    .dataout           (dataout),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty)
`ifdef RVV_UQ_ERR_EN
    ,
    .err_uq            (err_uq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       push;
    logic [3:0][31:0] d;
    logic [1:0]       pop;
    int               cnt;
    logic [31:0]      do0;
    logic [31:0]      do1;
    logic             err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] p, input logic [31:0] d3, input logic [31:0] d2,
                              input logic [31:0] d1, input logic [31:0] d0, input logic [1:0] pp,
                              input int c, input logic [31:0] o0, input logic [31:0] o1,
                              input logic e);
    vec_t v;
    v.push = p;
    v.d    = {d3, d2, d1, d0};
    v.pop  = pp;
    v.cnt  = c;
    v.do0  = o0;
    v.do1  = o1;
    v.err  = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags are defined directly by the occupancy, so derive them from the expected count.
  task automatic check_state(input string tag, input int cnt, input logic [31:0] o0,
                             input logic [31:0] o1, input logic e);
    logic [5:0] exp_flags;
    exp_flags = {cnt == 16, (16 - cnt) == 3, (16 - cnt) == 2, (16 - cnt) == 1, cnt == 0, cnt == 1};
    check({tag, " flags"}, {26'd0, fifo_full, fifo_almost_full, fifo_empty, fifo_almost_empty},
          {26'd0, exp_flags});
    if (cnt > 0) check({tag, " dataout0"}, dataout[0], o0);
    if (cnt > 1) check({tag, " dataout1"}, dataout[1], o1);
`ifdef RVV_UQ_ERR_EN
    check({tag, " err_uq"}, {31'd0, err_uq}, {31'd0, e});
`else
    if (e === 1'bx) check({tag, " err_uq"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) datain[i] = '0;

    //                  push     d3     d2     d1     d0   pop   cnt  do0    do1    err
    tbl.push_back(mk(4'b0111, 32'h0, 32'hC, 32'hB, 32'hA, 2'b00, 3, 32'hA, 32'hB, 1'b0));
    tbl.push_back(mk(4'b1111, 32'h4, 32'h3, 32'h2, 32'h1, 2'b00, 7, 32'hA, 32'hB, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 5, 32'hC, 32'h1, 1'b0));
    // Non-thermometer push: bits 1 and 3 compacted into two consecutive entries.
    tbl.push_back(mk(4'b1010, 32'h53, 32'h52, 32'h51, 32'h50, 2'b01, 6, 32'h1, 32'h2, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 5, 32'h2, 32'h3, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 3, 32'h4, 32'h51, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 1, 32'h53, 32'h0, 1'b0));
    // Underflow: count=1, pop two.
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 0, 32'h0, 32'h0, 1'b1));
    // Fill from index 9; the second burst wraps 13,14,15,0.
    tbl.push_back(mk(4'b1111, 32'h13, 32'h12, 32'h11, 32'h10, 2'b00, 4, 32'h10, 32'h11, 1'b1));
    tbl.push_back(mk(4'b1111, 32'h17, 32'h16, 32'h15, 32'h14, 2'b00, 8, 32'h10, 32'h11, 1'b1));
    tbl.push_back(mk(4'b1111, 32'h1B, 32'h1A, 32'h19, 32'h18, 2'b00, 12, 32'h10, 32'h11, 1'b1));
    tbl.push_back(mk(4'b1111, 32'h1F, 32'h1E, 32'h1D, 32'h1C, 2'b00, 16, 32'h10, 32'h11, 1'b1));
    tbl.push_back(mk(4'b0001, 32'h0, 32'h0, 32'h0, 32'hEE, 2'b00, 16, 32'h10, 32'h11, 1'b1));
    // Full with push and pop: push dropped, pop proceeds.
    tbl.push_back(mk(4'b1111, 32'hE3, 32'hE2, 32'hE1, 32'hE0, 2'b11, 14, 32'h12, 32'h13, 1'b1));
    tbl.push_back(mk(4'b1111, 32'h23, 32'h22, 32'h21, 32'h20, 2'b11, 14, 32'h14, 32'h15, 1'b1));
    // Read crossing index 15 -> 0.
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 12, 32'h16, 32'h17, 1'b1));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 10, 32'h18, 32'h19, 1'b1));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 9, 32'h19, 32'h1A, 1'b1));
    // Drain the two entries written when count was 14 (indices 9,10).
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 7, 32'h1B, 32'h1C, 1'b1));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 5, 32'h1D, 32'h1E, 1'b1));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 3, 32'h1F, 32'h20, 1'b1));
    tbl.push_back(mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 2, 32'h20, 32'h21, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < tbl.size(); v++) begin
      push = tbl[v].push;
      pop  = tbl[v].pop;
      for (int i = 0; i < 4; i++) datain[i] = tbl[v].d[i];
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].do0, tbl[v].do1, tbl[v].err);
    end

    // No bypass: a push into an empty queue is not visible until the next edge.
    push = '0;
    pop  = 2'b11;
    @(posedge clk);
    #1;
    pop  = 2'b11;
    @(posedge clk);
    #1;
    check_state("drained", 0, 32'h0, 32'h0, 1'b1);
    pop       = '0;
    push      = 4'b0001;
    datain[0] = 32'h66;
    #1;
    check_state("no_bypass", 0, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check_state("after_push", 1, 32'h66, 32'h0, 1'b1);

    // Build up to count 9 then reset asynchronously mid-burst.
    push = 4'b1111;
    for (int i = 0; i < 4; i++) datain[i] = 32'h80 + i;
    repeat (2) @(posedge clk);
    #1;
    check_state("pre_reset", 9, 32'h66, 32'h80, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_reset", 0, 32'h0, 32'h0, 1'b0);
    push = '0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    push      = 4'b0001;
    datain[0] = 32'h77;
    @(posedge clk);
    #1;
    check_state("post_reset", 1, 32'h77, 32'h0, 1'b0);
    push = '0;
    pop  = 2'b01;
    @(posedge clk);
    #1;
    check_state("post_reset_pop", 0, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
